// File: rtl/piso_pkg.sv
// piso_pkg: shared FSM state type for the parallel-in serial-out sender
package piso_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/bit_down_counter.sv
// bit_down_counter: loadable down counter that saturates at zero
module bit_down_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld,
   input  logic         dec,
   input  logic [W-1:0] pi,
   output logic [W-1:0] po
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = ld ? pi : (dec && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
   assign po = cnt_q;
endmodule

// File: rtl/piso_sender.sv
// piso_sender: captures a parallel word and emits it serially under sready handshake
module piso_sender
   import piso_pkg::*;
#(
   parameter int SIZE      = 10,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [SIZE-1:0] pi,
   input  logic            sready,
   output logic            ready,
   output logic            sout,
   output logic            svalid,
   output logic            busy,
   output logic            done
);
   localparam int CW = $clog2(SIZE + 1);
   state_t          state_q, state_d;
   logic [SIZE-1:0] sr_q, sr_d;
   logic [CW-1:0]   cnt;
   logic            ld, dec;
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      ld      = 1'b0;
      dec     = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = SHIFT;
            sr_d    = pi;
            ld      = 1'b1;
         end
         SHIFT: if (sready) begin
            dec     = 1'b1;
            sr_d    = MSB_FIRST ? sr_q << 1 : sr_q >> 1;
            state_d = (cnt == CW'(1)) ? DONE : SHIFT;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
      end
   end
   bit_down_counter #(.W(CW)) u_cnt (
      .clk(clk),
      .rst(rst),
      .ld (ld),
      .dec(dec),
      .pi (CW'(SIZE)),
      .po (cnt)
   );
   assign ready  = state_q == IDLE;
   assign svalid = state_q == SHIFT;
   assign busy   = state_q == SHIFT;
   assign done   = state_q == DONE;
   assign sout   = svalid & (MSB_FIRST ? sr_q[SIZE-1] : sr_q[0]);
endmodule

// File: doc/piso_sender.md
PISO_SENDER -- requirements
Module: piso_sender

Interface
REQ-001 SHALL provide parameter: SIZE, default 10, data word width in bits (SIZE >= 2).
REQ-002 SHALL provide parameter: MSB_FIRST, default 1; 1 = bit SIZE-1 sent first, 0 = bit 0 sent first.
REQ-003 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: start  input  1  request to capture pi and begin serial transmission.
REQ-006 SHALL have port: pi  input  SIZE  parallel word to transmit.
REQ-007 SHALL have port: sready  input  1  downstream accepts the current serial bit this cycle.
REQ-008 SHALL have port: ready  output  1  block is idle and will accept start.
REQ-009 SHALL have port: sout  output  1  current serial data bit.
REQ-010 SHALL have port: svalid  output  1  sout holds a valid bit.
REQ-011 SHALL have port: busy  output  1  a word is being transmitted.
REQ-012 SHALL have port: done  output  1  one-cycle pulse after the last bit is accepted.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-014 In IDLE, ready = 1; all other outputs = 0.
REQ-015 On a rising edge with start = 1 in IDLE, SHALL capture pi into the shift register, load the bit counter with SIZE, and enter SHIFT.
REQ-016 In SHIFT: svalid = 1, busy = 1, ready = 0, and sout = the current head bit (MSB or LSB, per MSB_FIRST).
REQ-017 A bit SHALL be consumed only on an edge with svalid = 1 and sready = 1: the register shifts toward the head and the counter decrements by 1.
REQ-018 With sready = 0, the shift register, counter and sout SHALL hold unchanged for any number of cycles.
REQ-019 When the counter equals 1 and the bit is consumed, SHALL enter DONE; exactly SIZE bits are emitted per word.
REQ-020 DONE SHALL last exactly one cycle with done = 1 and busy = 0, then return unconditionally to IDLE.
REQ-021 start SHALL be ignored in SHIFT and DONE; pi is sampled only at the accepting edge, so later pi changes do not affect the word in flight.
REQ-022 Minimum word latency: the first bit is valid 1 cycle after the accepting edge, and done rises SIZE+1 cycles after it when sready is held at 1.
REQ-023 Back-to-back words: start may be accepted in the cycle after DONE, giving a 2-cycle gap between the last bit and the first bit of the next word.
REQ-024 Counter width SHALL be $clog2(SIZE+1); the counter never wraps below 0.
REQ-025 The shift register SHALL fill vacated positions with 0.

Reset
REQ-026 rst = 1 SHALL immediately, independent of clk, force state IDLE, shift register 0 and counter 0.
REQ-027 During and after reset: ready = 1; sout, svalid, busy and done = 0.
REQ-028 Reset mid-word SHALL abort the transfer with no done pulse; the next start SHALL begin a fresh word.

Structure
REQ-029 Shared package piso_pkg SHALL hold the state enum type (IDLE, SHIFT, DONE).
REQ-030 The bit counter SHALL be a separate sub-module named bit_down_counter, with ports clk, rst, ld, dec, pi, po and parameterized width.
REQ-031 The FSM, shift register and output decode SHALL reside in piso_sender; outputs SHALL be decoded from the registered state.

Verification
REQ-032 Reset, then idle with start = 0 -> ready = 1, svalid = 0, done = 0 for 5 cycles.
REQ-033 SIZE = 10, MSB_FIRST = 1, pi = 10'b1011001110, sready held at 1 -> sout = 1,0,1,1,0,0,1,1,1,0 on consecutive cycles, then done pulses at cycle 11.
REQ-034 Same word with MSB_FIRST = 0 -> sout = 0,1,1,1,0,0,1,1,0,1.
REQ-035 sready = 0 for 3 cycles after bit 4 -> sout holds bit 4 for 4 cycles total; sequence otherwise intact; done at cycle 14.
REQ-036 start pulsed and pi changed mid-word -> no effect on the word in flight; a start on the cycle after DONE begins the next word.
REQ-037 rst asserted after bit 6 -> outputs return immediately to reset values, no done pulse; a new word then transmits correctly.
